ram_banked: RTL

Parametrised, synchronous, single-port banked RAM; the next generation of the fixed 16K-word memory. Word width, total depth and bank count are parameters. The address MSBs select a bank and the LSBs select a word within it. Reads are registered and carry a valid strobe. An optional post-reset clear sweep zeroes every word before the block reports ready. It sits between the CPU datapath and the memory map as the main data RAM.

---
 rtl/ram_banked.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ram_banked.sv
// ram_banked: parametrised single-port banked RAM with registered reads.
// The upper BANK_BITS address bits select a bank and the remaining bits
// select a word inside it. Read data is registered and tagged by out_valid.
//
// Optional feature macro: RAM_BANKED_CLEAR_EN
//   defined   : after reset a sweep zeroes every word (all banks in
//               parallel, one index per cycle) before ready rises.
//   undefined : no sweep; ready rises one edge after reset release and
//               memory contents are undefined until written.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   reset      asynchronous active-high reset
//   in         write data (WIDTH)
//   address    word address (ADDR_BITS); MSBs = bank, LSBs = word offset
//   load       with req: 1 = write, 0 = read
//   req        access request
//   out        registered read data, holds between reads
//   out_valid  one-cycle pulse marking new data on out
//   ready      block accepts requests
module ram_banked #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned BANK_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 load,
  input  logic                 req,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  output logic                 ready
);

  localparam int unsigned OFFS_BITS  = ADDR_BITS - BANK_BITS;
  localparam int unsigned NUM_BANKS  = 1 << BANK_BITS;
  localparam int unsigned BANK_DEPTH = 1 << OFFS_BITS;
  // Bank-select needs at least one bit even for a single-bank build.
  localparam int unsigned SEL_W      = (BANK_BITS > 0) ? BANK_BITS : 1;

  logic [SEL_W-1:0]     bank_sel_c;
  logic [OFFS_BITS-1:0] offset_c;
  logic [OFFS_BITS-1:0] wr_idx_c;
  logic [WIDTH-1:0]     wr_data_c;
  logic [NUM_BANKS-1:0] we_c;
  logic [WIDTH-1:0]     rd_word_c [NUM_BANKS];
  logic [WIDTH-1:0]     rd_sel_c;
  logic                 clr_c;
  logic                 wr_c;
  logic                 rd_c;

  logic [WIDTH-1:0]     out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ready_q, ready_d;

  // Address split into bank select and in-bank offset.
  if (BANK_BITS > 0) begin : g_sel
    assign bank_sel_c = address[ADDR_BITS-1 -: SEL_W];
  end else begin : g_nosel
    assign bank_sel_c = '0;
  end
  assign offset_c = address[OFFS_BITS-1:0];

  // Requests are only honoured once ready; otherwise dropped silently.
  assign wr_c = ready_q & req & load;
  assign rd_c = ready_q & req & ~load;

`ifdef RAM_BANKED_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [OFFS_BITS-1:0] sweep_q, sweep_d;

  // State and sweep counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Sweep control: zero one index in every bank per cycle until wrap.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready_d = ready_q;
    clr_c   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_c   = 1'b1;
        sweep_d = sweep_q + OFFS_BITS'(1);
        if (sweep_q == '1) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      end
      ST_READY: begin
        ready_d = 1'b1;
      end
    endcase
  end

  assign wr_idx_c = clr_c ? sweep_q : offset_c;
`else
  // Without the sweep the FSM collapses to a ready flag set on the first edge.
  assign clr_c    = 1'b0;
  assign ready_d  = 1'b1;
  assign wr_idx_c = offset_c;
`endif

  assign wr_data_c = clr_c ? '0 : in;

  // Bank storage: the sweep enables every bank, a write only the addressed one.
  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    logic [WIDTH-1:0] mem_q [BANK_DEPTH];

    assign we_c[b] = clr_c | (wr_c & (bank_sel_c == SEL_W'(b)));

    always_ff @(posedge clk) begin
      if (we_c[b]) begin
        mem_q[wr_idx_c] <= wr_data_c;
      end
    end

    assign rd_word_c[b] = mem_q[offset_c];
  end

  // Bank read mux.
  always_comb begin
    rd_sel_c = '0;
    for (int i = 0; i < int'(NUM_BANKS); i++) begin
      if (bank_sel_c == SEL_W'(i)) begin
        rd_sel_c = rd_word_c[i];
      end
    end
  end

  // Read data holds between reads; valid pulses only for accepted reads.
  always_comb begin
    out_d       = out_q;
    out_valid_d = rd_c;
    if (rd_c) begin
      out_d = rd_sel_c;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign ready     = ready_q;

endmodule
